// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg
// Shared definitions for the decode-stage register file slice: default
// geometry of the architectural register file, the hardwired zero register
// address and the register-address type used by the ID stage.
// ============================================================================
package mips_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_ADDR_W   = 5;

    // Architectural register that always reads as zero.
    localparam logic [DEFAULT_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

endpackage : mips_pkg

// File: rtl/decode_rf_read_port.sv
// ============================================================================
// decode_rf_read_port
// One combinational read port of the decode register file.
//   rst_n    in   reset level; while low the port reports zero / not busy
//   rd_addr  in   register to read
//   regs     in   current contents of the storage array
//   busy     in   current scoreboard vector
//   wr_en    in   write-back enable this cycle
//   wr_addr  in   write-back destination
//   wr_data  in   write-back data
//   rd_data  out  read data (zero register, bypassed or stored value)
//   rd_busy  out  source has an outstanding producer not satisfied this cycle
// ============================================================================
module decode_rf_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic zero_hit_s;
    logic wr_ok_s;
    logic byp_hit_s;

    // A read of the zero register, or a write to it, never carries data.
    assign zero_hit_s = (ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO));
    assign wr_ok_s    = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));
    assign byp_hit_s  = (BYPASS != 0) && wr_ok_s && (wr_addr == rd_addr);

    // Read selection: reset and zero register dominate, then bypass, then storage.
    // The bypass also satisfies the hazard, so busy is masked on a bypass hit.
    always_comb begin
        rd_data = {DATA_W{1'b0}};
        rd_busy = 1'b0;
        if (!rst_n) begin
            // Keeps a write presented during reset from leaking through the bypass.
            rd_data = {DATA_W{1'b0}};
            rd_busy = 1'b0;
        end else if (zero_hit_s) begin
            rd_data = {DATA_W{1'b0}};
            rd_busy = 1'b0;
        end else if (byp_hit_s) begin
            rd_data = wr_data;
            rd_busy = 1'b0;
        end else begin
            rd_data = regs[rd_addr];
            rd_busy = busy[rd_addr];
        end
    end

endmodule : decode_rf_read_port

// File: rtl/decode_register_file.sv
// ============================================================================
// decode_register_file
// Decode-stage register file: NUM_RD combinational read ports, one
// synchronous write port, optional hardwired zero register, optional
// same-cycle write->read bypass and a per-register busy scoreboard.
//   clk          in   clock, state updates on rising edge
//   rst_n        in   asynchronous active-low reset
//   rd_addr      in   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data      out  read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy      out  port i source has an outstanding producer
//   wr_en        in   write enable from write-back
//   wr_addr      in   write-back destination
//   wr_data      in   write-back data
//   sb_set_en    in   mark a destination busy (issue from ID)
//   sb_set_addr  in   destination to mark busy
// ============================================================================
module decode_register_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr
);

    logic [DATA_W-1:0]   reg_file_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_next_s;
    logic [NUM_REGS-1:0] clr_vec_s;
    logic [NUM_REGS-1:0] set_vec_s;
    logic                wr_ok_s;

    // Writes to the zero register are dropped so it keeps reading zero.
    assign wr_ok_s = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));

    // Storage array: async clear, one write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_file_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            reg_file_r[wr_addr] <= wr_data;
        end
    end

    // Scoreboard next state: write-back clears, issue sets. The set is applied
    // after the clear so a same-cycle collision leaves the newer producer busy.
    always_comb begin
        clr_vec_s = {NUM_REGS{1'b0}};
        set_vec_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            clr_vec_s[i] = wr_en && (wr_addr == ADDR_W'(i));
            set_vec_s[i] = sb_set_en && (sb_set_addr == ADDR_W'(i));
        end
        busy_next_s = (busy_r & ~clr_vec_s) | set_vec_s;
        if (ZERO_REG != 0) begin
            busy_next_s[0] = 1'b0;
        end else begin
            busy_next_s[0] = busy_next_s[0];
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // One read port per requested source operand.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
        decode_rf_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_read_port (
            .rst_n   (rst_n),
            .rd_addr (rd_addr[p*ADDR_W +: ADDR_W]),
            .regs    (reg_file_r),
            .busy    (busy_r),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[p*DATA_W +: DATA_W]),
            .rd_busy (rd_busy[p])
        );
    end

endmodule : decode_register_file

// File: tb/tb_decode_register_file.sv
// ============================================================================
// tb_decode_register_file
// Two instances: A = default geometry with bypass, B = 3 ports, 64-bit,
// 16 registers, no bypass. Both are compared against a reference model of
// the architectural state (register values and busy flags).
// ============================================================================
module tb_decode_register_file;

    logic clk;
    logic rst_n;

    // Instance A: 2 ports x 32 bits, 32 regs, bypass on
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_sb_set_en;
    logic [4:0]  a_sb_set_addr;

    // Instance B: 3 ports x 64 bits, 16 regs, bypass off
    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic         b_wr_en;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_sb_set_en;
    logic [3:0]   b_sb_set_addr;

    // Reference architectural state
    logic [31:0] a_mem  [32];
    bit          a_busy [32];
    logic [63:0] b_mem  [16];
    bit          b_busy [16];

    int vec_cnt    = 0;
    int miscompares = 0;

    decode_register_file u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (a_rd_addr),
        .rd_data     (a_rd_data),
        .rd_busy     (a_rd_busy),
        .wr_en       (a_wr_en),
        .wr_addr     (a_wr_addr),
        .wr_data     (a_wr_data),
        .sb_set_en   (a_sb_set_en),
        .sb_set_addr (a_sb_set_addr)
    );

    decode_register_file #(
        .DATA_W   (64),
        .NUM_REGS (16),
        .ADDR_W   (4),
        .NUM_RD   (3),
        .ZERO_REG (1),
        .BYPASS   (0)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (b_rd_addr),
        .rd_data     (b_rd_data),
        .rd_busy     (b_rd_busy),
        .wr_en       (b_wr_en),
        .wr_addr     (b_wr_addr),
        .wr_data     (b_wr_data),
        .sb_set_en   (b_sb_set_en),
        .sb_set_addr (b_sb_set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Expected read value: reset and r0 read zero; with bypass a matching
    // write is visible now, otherwise the architectural value is returned.
    function automatic logic [31:0] a_exp_data(input logic [4:0] ra);
        if (!rst_n || ra == 5'd0) return 32'd0;
        if (a_wr_en && a_wr_addr == ra) return a_wr_data;
        return a_mem[ra];
    endfunction

    function automatic logic a_exp_busy(input logic [4:0] ra);
        if (!rst_n || ra == 5'd0) return 1'b0;
        if (a_wr_en && a_wr_addr == ra) return 1'b0;
        return a_busy[ra];
    endfunction

    function automatic logic [63:0] b_exp_data(input logic [3:0] ra);
        if (!rst_n || ra == 4'd0) return 64'd0;
        return b_mem[ra];
    endfunction

    function automatic logic b_exp_busy(input logic [3:0] ra);
        if (!rst_n || ra == 4'd0) return 1'b0;
        return b_busy[ra];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin a_mem[i] = 32'd0; a_busy[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin b_mem[i] = 64'd0; b_busy[i] = 1'b0; end
    endtask

    // Advance the reference state by one rising edge using the held inputs.
    task automatic model_update();
        if (!rst_n) begin
            model_clear();
        end else begin
            if (a_wr_en && a_wr_addr != 5'd0) a_mem[a_wr_addr] = a_wr_data;
            if (a_wr_en) a_busy[a_wr_addr] = 1'b0;
            if (a_sb_set_en && a_sb_set_addr != 5'd0) a_busy[a_sb_set_addr] = 1'b1;
            if (b_wr_en && b_wr_addr != 4'd0) b_mem[b_wr_addr] = b_wr_data;
            if (b_wr_en) b_busy[b_wr_addr] = 1'b0;
            if (b_sb_set_en && b_sb_set_addr != 4'd0) b_busy[b_sb_set_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [4:0] ra;
        logic [3:0] rb;
        for (int i = 0; i < 2; i++) begin
            ra = a_rd_addr[i*5 +: 5];
            check_val($sformatf("a_data%0d r%0d", i, ra), {32'd0, a_rd_data[i*32 +: 32]}, {32'd0, a_exp_data(ra)});
            check_val($sformatf("a_busy%0d r%0d", i, ra), {63'd0, a_rd_busy[i]}, {63'd0, a_exp_busy(ra)});
        end
        for (int i = 0; i < 3; i++) begin
            rb = b_rd_addr[i*4 +: 4];
            check_val($sformatf("b_data%0d r%0d", i, rb), b_rd_data[i*64 +: 64], b_exp_data(rb));
            check_val($sformatf("b_busy%0d r%0d", i, rb), {63'd0, b_rd_busy[i]}, {63'd0, b_exp_busy(rb)});
        end
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        a_wr_en = 1'b0; a_sb_set_en = 1'b0;
        b_wr_en = 1'b0; b_sb_set_en = 1'b0;
    endtask

    task automatic drive_random();
        a_wr_en       = 1'($urandom_range(0, 1));
        a_wr_addr     = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        a_wr_data     = $urandom;
        a_sb_set_en   = 1'($urandom_range(0, 1));
        a_sb_set_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        for (int i = 0; i < 2; i++) begin
            a_rd_addr[i*5 +: 5] = ($urandom_range(0, 2) == 0) ? a_wr_addr : 5'($urandom_range(0, 7));
        end
        b_wr_en       = 1'($urandom_range(0, 1));
        b_wr_addr     = 4'($urandom_range(0, 15));
        b_wr_data     = {$urandom, $urandom};
        b_sb_set_en   = 1'($urandom_range(0, 1));
        b_sb_set_addr = 4'($urandom_range(0, 15));
        for (int i = 0; i < 3; i++) begin
            b_rd_addr[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? b_wr_addr : 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        a_wr_addr = 5'd0; a_wr_data = 32'd0; a_sb_set_addr = 5'd0; a_rd_addr = 10'd0;
        b_wr_addr = 4'd0; b_wr_data = 64'd0; b_sb_set_addr = 4'd0; b_rd_addr = 12'd0;
        model_clear();

        // Reset state, including a write presented while reset is held
        tick();
        a_wr_en = 1'b1; a_wr_addr = 5'd2; a_wr_data = 32'hAAAA5555;
        a_rd_addr = {5'd2, 5'd2};
        settle();
        check_val("reset_a_data", {32'd0, a_rd_data[31:0]}, 64'd0);
        tick();
        rst_n = 1'b1;
        idle();

        // Zero register ignores writes
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h0000000F;
        a_rd_addr = {5'd2, 5'd0};
        settle();
        check_val("t2_zero_same", {32'd0, a_rd_data[31:0]}, 64'd0);
        tick();
        idle();
        settle();
        check_val("t2_zero_next", {32'd0, a_rd_data[31:0]}, 64'd0);
        check_val("t2_r2_reset_lost", {32'd0, a_rd_data[63:32]}, 64'd0);

        // Write/read: bypass on A, stored value on B
        a_wr_en = 1'b1; a_wr_addr = 5'd1; a_wr_data = 32'h0003C00F;
        a_rd_addr = {5'd1, 5'd1};
        b_wr_en = 1'b1; b_wr_addr = 4'd1; b_wr_data = 64'h0003C00F;
        b_rd_addr = {4'd1, 4'd1, 4'd1};
        settle();
        check_val("t3_a_byp0", {32'd0, a_rd_data[31:0]},  64'h0003C00F);
        check_val("t3_a_byp1", {32'd0, a_rd_data[63:32]}, 64'h0003C00F);
        check_val("t3_b_old",  b_rd_data[63:0], 64'd0);
        tick();
        idle();
        settle();
        check_val("t3_b_new",  b_rd_data[127:64], 64'h0003C00F);

        // Scoreboard set then clearing write
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd5;
        a_rd_addr = {5'd5, 5'd5};
        settle();
        tick();
        idle();
        settle();
        check_val("t4_busy_set", {63'd0, a_rd_busy[0]}, 64'd1);
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'h12345678;
        settle();
        check_val("t4_busy_masked", {63'd0, a_rd_busy[1]}, 64'd0);
        check_val("t4_byp_data", {32'd0, a_rd_data[31:0]}, 64'h12345678);
        tick();
        idle();
        settle();
        check_val("t4_busy_clear", {63'd0, a_rd_busy[0]}, 64'd0);

        // Set/clear collision: set wins
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd7;
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'hCAFE0007;
        a_rd_addr = {5'd7, 5'd7};
        settle();
        tick();
        idle();
        settle();
        check_val("t5_busy", {63'd0, a_rd_busy[0]}, 64'd1);
        check_val("t5_data", {32'd0, a_rd_data[63:32]}, 64'hCAFE0007);

        // Wide three-port instance: r3, r15, r0
        b_wr_en = 1'b1; b_wr_addr = 4'd3; b_wr_data = 64'h0123456789ABCDEF;
        tick();
        b_wr_addr = 4'd15; b_wr_data = 64'hFEDCBA9876543210;
        tick();
        b_wr_addr = 4'd0; b_wr_data = 64'hFFFFFFFFFFFFFFFF;
        tick();
        idle();
        b_rd_addr = {4'd0, 4'd15, 4'd3};
        settle();
        check_val("t6_r3",  b_rd_data[63:0],    64'h0123456789ABCDEF);
        check_val("t6_r15", b_rd_data[127:64],  64'hFEDCBA9876543210);
        check_val("t6_r0",  b_rd_data[191:128], 64'd0);

        // Asynchronous reset mid-run, with a write in flight
        a_wr_en = 1'b1; a_wr_addr = 5'd1; a_wr_data = 32'hDEADBEEF;
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd9;
        a_rd_addr = {5'd7, 5'd1};
        #2;
        rst_n = 1'b0;
        settle();
        check_val("t1_a_data1", {32'd0, a_rd_data[31:0]}, 64'd0);
        check_val("t1_a_busy7", {62'd0, a_rd_busy}, 64'd0);
        check_val("t1_b_data",  b_rd_data[63:0], 64'd0);
        tick();
        rst_n = 1'b1;
        idle();
        settle();
        check_val("t1_write_lost", {32'd0, a_rd_data[31:0]}, 64'd0);

        // Randomized traffic with one mid-run reset
        for (int n = 0; n < 400; n++) begin
            drive_random();
            if (n == 200) rst_n = 1'b0;
            if (n == 203) rst_n = 1'b1;
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule : tb_decode_register_file
